// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_mc multi-cycle RV32I/RV32E core.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH_SETUP = 3'd0,
        ST_FETCH       = 3'd1,
        ST_DECODE      = 3'd2,
        ST_MEM_REQ     = 3'd3,
        ST_MEM_WAIT    = 3'd4,
        ST_WRITEBACK   = 3'd5,
        ST_ERROR       = 3'd6
    } cpu_state_t;

    // alt is instr[30]; it selects sub only for register-register ops
    function automatic alu_op_t alu_op_for(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_t op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU shared by address, branch-target and arithmetic paths.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     op_i,
    output logic [31:0] y_o
);

    // result select; shifts use only the low five bits of b
    always_comb begin
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << b_i[4:0];
            ALU_SLT:  y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: y_o = {31'd0, (a_i < b_i)};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> b_i[4:0];
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module cpu_load_align (
    input  logic [31:0] read_data_i,
    input  logic [1:0]  ea_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // lane extract then extend according to the load width
    always_comb begin
        shifted_s = read_data_i >> {ea_i, 3'b000};
        case (funct3_i)
            3'b000:  data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b100:  data_o = {24'd0, shifted_s[7:0]};
            3'b101:  data_o = {16'd0, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I/RV32E core on a single-port request/ready memory bus.
module cpu_mc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h10000000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ready,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic [3:0]  byte_enable,
    output logic        write_req,
    output logic        read_req,
    input  logic [31:0] read_data,
    input  logic        read_data_valid,
    output logic        retire,
    output logic        error
);

    localparam int IDX_W = (NUM_REGS == 16) ? 4 : 5;

    cpu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, op_a_q, op_a_d, op_b_q, op_b_d;
    alu_op_t     alu_op_q, alu_op_d;
    logic [1:0]  ea_q, ea_d;
    logic [31:0] ld_data_q, ld_data_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_pend_q, rd_pend_d, read_req_q, read_req_d, write_req_q, write_req_d;
    logic        retire_q, retire_d, error_q, error_d;
    logic [31:0] regs_q [NUM_REGS];

    logic [6:0]  opcode_s, f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_val_s, rs2_val_s, alu_y_s, align_s, pc_plus4_s, pc_next_s, wb_data_s;
    logic        rd_accept_s, decode_err_s, misaligned_s, taken_s, writes_rd_s, rf_we_s;

    function automatic logic reg_bad(input logic [4:0] idx);
        return (NUM_REGS < 32) && idx[4];
    endfunction

    assign opcode_s   = instr_q[6:0];
    assign rd_s       = instr_q[11:7];
    assign f3_s       = instr_q[14:12];
    assign rs1_s      = instr_q[19:15];
    assign rs2_s      = instr_q[24:20];
    assign f7_s       = instr_q[31:25];
    assign imm_i_s    = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b_s    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u_s    = {instr_q[31:12], 12'd0};
    assign imm_j_s    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    assign rs1_val_s  = regs_q[rs1_s[IDX_W-1:0]];
    assign rs2_val_s  = regs_q[rs2_s[IDX_W-1:0]];
    assign pc_plus4_s = pc_q + 32'd4;
    // data may arrive in the same cycle the read is accepted; stray valids are ignored
    assign rd_accept_s = read_data_valid && (rd_pend_q || (read_req_q && ready));
    assign misaligned_s = ((f3_s[1:0] == 2'b01) && alu_y_s[0]) ||
                          ((f3_s[1:0] == 2'b10) && (alu_y_s[1:0] != 2'b00));

    alu u_alu (.a_i(op_a_q), .b_i(op_b_q), .op_i(alu_op_q), .y_o(alu_y_s));

    cpu_load_align u_align (.read_data_i(read_data), .ea_i(ea_q), .funct3_i(f3_s), .data_o(align_s));

    // instruction legality: opcode, funct3/funct7 and register range
    always_comb begin
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: decode_err_s = reg_bad(rd_s);
            OPC_JALR:   decode_err_s = (f3_s != 3'b000) || reg_bad(rd_s) || reg_bad(rs1_s);
            OPC_BRANCH: decode_err_s = (f3_s[2:1] == 2'b01) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OPC_LOAD:   decode_err_s = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11) || reg_bad(rd_s) || reg_bad(rs1_s);
            OPC_STORE:  decode_err_s = f3_s[2] || (f3_s == 3'b011) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OPC_OPIMM:  decode_err_s = ((f3_s == 3'b001) && (f7_s != 7'h00)) ||
                                       ((f3_s == 3'b101) && (f7_s != 7'h00) && (f7_s != 7'h20)) ||
                                       reg_bad(rd_s) || reg_bad(rs1_s);
            OPC_OP:     decode_err_s = !((f7_s == 7'h00) || ((f7_s == 7'h20) && ((f3_s == 3'b000) || (f3_s == 3'b101)))) ||
                                       reg_bad(rd_s) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OPC_FENCE, OPC_SYSTEM: decode_err_s = 1'b0;
            default:    decode_err_s = 1'b1;
        endcase
    end

    // dedicated branch comparator, next pc and writeback value
    always_comb begin
        case (f3_s)
            3'b000:  taken_s = (rs1_val_s == rs2_val_s);
            3'b001:  taken_s = (rs1_val_s != rs2_val_s);
            3'b100:  taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            3'b101:  taken_s = !($signed(rs1_val_s) < $signed(rs2_val_s));
            3'b110:  taken_s = (rs1_val_s < rs2_val_s);
            3'b111:  taken_s = !(rs1_val_s < rs2_val_s);
            default: taken_s = 1'b0;
        endcase
        case (opcode_s)
            OPC_JAL:    pc_next_s = alu_y_s;
            OPC_JALR:   pc_next_s = {alu_y_s[31:1], 1'b0};
            OPC_BRANCH: pc_next_s = taken_s ? alu_y_s : pc_plus4_s;
            default:    pc_next_s = pc_plus4_s;
        endcase
        case (opcode_s)
            OPC_LOAD:           wb_data_s = ld_data_q;
            OPC_JAL, OPC_JALR:  wb_data_s = pc_plus4_s;
            default:            wb_data_s = alu_y_s;
        endcase
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP, OPC_LOAD: writes_rd_s = 1'b1;
            default: writes_rd_s = 1'b0;
        endcase
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH_SETUP: state_d = ST_FETCH;
            ST_FETCH:       state_d = rd_accept_s ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (decode_err_s) begin
                    state_d = ST_ERROR;
                end else if ((opcode_s == OPC_LOAD) || (opcode_s == OPC_STORE)) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM_REQ:     state_d = misaligned_s ? ST_ERROR : ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (opcode_s == OPC_STORE) begin
                    state_d = (write_req_q && ready) ? ST_WRITEBACK : ST_MEM_WAIT;
                end else begin
                    state_d = rd_accept_s ? ST_WRITEBACK : ST_MEM_WAIT;
                end
            end
            ST_WRITEBACK:   state_d = (pc_next_s[1:0] != 2'b00) ? ST_ERROR : ST_FETCH;
            ST_ERROR:       state_d = ST_ERROR;
            default:        state_d = ST_ERROR;
        endcase
    end

    // datapath and bus output next values
    always_comb begin
        pc_d = pc_q;  instr_d = instr_q;  op_a_d = op_a_q;  op_b_d = op_b_q;
        alu_op_d = alu_op_q;  ea_d = ea_q;  ld_data_d = ld_data_q;
        addr_d = addr_q;  wdata_d = wdata_q;  be_d = be_q;
        read_req_d = read_req_q;  write_req_d = write_req_q;
        retire_d = 1'b0;  rf_we_s = 1'b0;
        error_d = (state_d == ST_ERROR);
        if (rd_accept_s) begin
            rd_pend_d = 1'b0;
        end else if (read_req_q && ready) begin
            rd_pend_d = 1'b1;
        end else begin
            rd_pend_d = rd_pend_q;
        end
        if (read_req_q && ready) begin
            read_req_d = 1'b0;
        end else begin
            read_req_d = read_req_q;
        end
        if (write_req_q && ready) begin
            write_req_d = 1'b0;
        end else begin
            write_req_d = write_req_q;
        end
        case (state_q)
            ST_FETCH_SETUP: begin
                read_req_d = 1'b1;  addr_d = pc_q;  be_d = 4'hf;
            end
            ST_FETCH: begin
                if (rd_accept_s) begin
                    instr_d = read_data;
                end else begin
                    instr_d = instr_q;
                end
            end
            ST_DECODE: begin
                alu_op_d = ALU_ADD;
                op_a_d   = rs1_val_s;
                op_b_d   = imm_i_s;
                case (opcode_s)
                    OPC_LUI:    begin op_a_d = 32'd0;  op_b_d = imm_u_s; end
                    OPC_AUIPC:  begin op_a_d = pc_q;   op_b_d = imm_u_s; end
                    OPC_JAL:    begin op_a_d = pc_q;   op_b_d = imm_j_s; end
                    OPC_BRANCH: begin op_a_d = pc_q;   op_b_d = imm_b_s; end
                    OPC_STORE:  op_b_d = imm_s_s;
                    OPC_OPIMM:  alu_op_d = alu_op_for(f3_s, instr_q[30], 1'b0);
                    OPC_OP:     begin op_b_d = rs2_val_s; alu_op_d = alu_op_for(f3_s, instr_q[30], 1'b1); end
                    default:    op_b_d = imm_i_s;
                endcase
            end
            ST_MEM_REQ: begin
                if (!misaligned_s) begin
                    addr_d = {alu_y_s[31:2], 2'b00};
                    ea_d   = alu_y_s[1:0];
                    if (opcode_s == OPC_STORE) begin
                        write_req_d = 1'b1;
                        case (f3_s[1:0])
                            2'b00:   begin be_d = 4'b0001 << alu_y_s[1:0]; wdata_d = {4{rs2_val_s[7:0]}}; end
                            2'b01:   begin be_d = 4'b0011 << alu_y_s[1:0]; wdata_d = {2{rs2_val_s[15:0]}}; end
                            default: begin be_d = 4'hf; wdata_d = rs2_val_s; end
                        endcase
                    end else begin
                        read_req_d = 1'b1;  be_d = 4'hf;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_MEM_WAIT: begin
                if ((opcode_s == OPC_LOAD) && rd_accept_s) begin
                    ld_data_d = align_s;
                end else begin
                    ld_data_d = ld_data_q;
                end
            end
            ST_WRITEBACK: begin
                if (pc_next_s[1:0] == 2'b00) begin
                    rf_we_s    = writes_rd_s && (rd_s != 5'd0);
                    retire_d   = 1'b1;
                    pc_d       = pc_next_s;
                    read_req_d = 1'b1;  addr_d = pc_next_s;  be_d = 4'hf;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            ST_ERROR: begin
                read_req_d = 1'b0;  write_req_d = 1'b0;  rd_pend_d = 1'b0;
            end
            default: begin
                read_req_d = 1'b0;  write_req_d = 1'b0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH_SETUP;  pc_q <= RESET_PC;  instr_q <= 32'd0;
            op_a_q <= 32'd0;  op_b_q <= 32'd0;  alu_op_q <= ALU_ADD;  ea_q <= 2'd0;
            ld_data_q <= 32'd0;  addr_q <= 32'd0;  wdata_q <= 32'd0;  be_q <= 4'd0;
            rd_pend_q <= 1'b0;  read_req_q <= 1'b0;  write_req_q <= 1'b0;
            retire_q <= 1'b0;  error_q <= 1'b0;
        end else begin
            state_q <= state_d;  pc_q <= pc_d;  instr_q <= instr_d;
            op_a_q <= op_a_d;  op_b_q <= op_b_d;  alu_op_q <= alu_op_d;  ea_q <= ea_d;
            ld_data_q <= ld_data_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  be_q <= be_d;
            rd_pend_q <= rd_pend_d;  read_req_q <= read_req_d;  write_req_q <= write_req_d;
            retire_q <= retire_d;  error_q <= error_d;
        end
    end

    // architectural register file; x0 is never written so it reads zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (rf_we_s) begin
            regs_q[rd_s[IDX_W-1:0]] <= wb_data_s;
        end
    end

    assign addr        = addr_q;
    assign write_data  = wdata_q;
    assign byte_enable = be_q;
    assign write_req   = write_req_q;
    assign read_req    = read_req_q;
    assign retire      = retire_q;
    assign error       = error_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: small programs in a bus-model memory, stores checked via a scoreboard.
module tb_cpu_mc;
    import cpu_pkg::*;

    localparam logic [31:0] BASE = 32'h10000000;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready = 1'b0;
    logic        read_data_valid = 1'b0;
    logic [31:0] read_data = 32'd0;
    logic [31:0] addr, write_data;
    logic [3:0]  byte_enable;
    logic        write_req, read_req, retire, error;

    logic [31:0] mem [int];
    wr_t         exp_wr_q [$];
    wr_t         obs_wr_q [$];
    int          errors = 0;
    int          checks = 0;
    int          ret_cnt = 0;
    int          rd_cnt = 0;
    int          ret0, rd0;
    logic        hold = 1'b0;
    logic        hold_wr = 1'b0;
    logic [31:0] pp;

    cpu_mc #(.RESET_PC(BASE), .NUM_REGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .addr(addr),
        .write_data(write_data), .byte_enable(byte_enable), .write_req(write_req),
        .read_req(read_req), .read_data(read_data), .read_data_valid(read_data_valid),
        .retire(retire), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (mem.exists(k)) return mem[k];
        return 32'd0;
    endfunction

    // zero-wait memory responder, sampled and driven on the falling edge
    always @(negedge clk) begin
        ready = !(hold || (hold_wr && write_req));
        if (retire) ret_cnt++;
        if (read_req && ready) begin
            read_data = mem_rd(addr);
            read_data_valid = 1'b1;
            rd_cnt++;
        end else begin
            read_data_valid = 1'b0;
        end
        if (write_req && ready) obs_wr_q.push_back('{addr, byte_enable, write_data});
    end

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    task automatic emit(input logic [31:0] w);
        mem[int'(pp >> 2)] = w;
        pp = pp + 32'd4;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_wr_q.push_back('{a, be, d});
    endtask

    task automatic start_reset();
        reset_n = 1'b0;
        hold = 1'b0;
        hold_wr = 1'b0;
        mem.delete();
        exp_wr_q.delete();
        obs_wr_q.delete();
        pp = BASE;
        repeat (2) @(negedge clk);
        check("reset_bus", {4'd0, addr, byte_enable, write_data}, 68'd0);
        check("reset_ctl", {64'd0, read_req, write_req, retire, error}, 68'd0);
    endtask

    task automatic release_reset();
        ret0 = ret_cnt;
        rd0 = rd_cnt;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic finish_prog(input string tag, input int exp_ret, input int exp_rd);
        wr_t o, e;
        int  n;
        n = 0;
        while (!error && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_error"}, {67'd0, error}, 68'd1);
        check({tag, "_retires"}, 68'(ret_cnt - ret0), 68'(exp_ret));
        if (exp_rd >= 0) check({tag, "_reads"}, 68'(rd_cnt - rd0), 68'(exp_rd));
        while (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            if (obs_wr_q.size() == 0) begin
                check({tag, "_missing_wr"}, 68'd0, e);
            end else begin
                o = obs_wr_q.pop_front();
                check({tag, "_wr"}, o, e);
            end
        end
        check({tag, "_extra_wr"}, 68'(obs_wr_q.size()), 68'd0);
    endtask

    initial begin
        // addi then store word
        start_reset();
        emit(i_t(12'hFFB, 5'd0, 3'b000, 5'd1, OPC_OPIMM));
        emit(s_t(12'h100, 5'd1, 5'd0, 3'b010));
        expect_wr(32'h100, 4'hf, 32'hFFFFFFFB);
        release_reset();
        finish_prog("addi_sw", 2, -1);

        // byte/half loads, positive data
        start_reset();
        mem[int'(32'h200 >> 2)] = 32'h11223344;
        emit(i_t(12'h203, 5'd0, 3'b000, 5'd2, OPC_LOAD));
        emit(i_t(12'h203, 5'd0, 3'b100, 5'd3, OPC_LOAD));
        emit(i_t(12'h202, 5'd0, 3'b001, 5'd4, OPC_LOAD));
        emit(s_t(12'h300, 5'd2, 5'd0, 3'b010));
        emit(s_t(12'h304, 5'd3, 5'd0, 3'b010));
        emit(s_t(12'h308, 5'd4, 5'd0, 3'b010));
        expect_wr(32'h300, 4'hf, 32'h00000011);
        expect_wr(32'h304, 4'hf, 32'h00000011);
        expect_wr(32'h308, 4'hf, 32'h00001122);
        release_reset();
        finish_prog("load_pos", 6, -1);

        // byte/half loads, negative data
        start_reset();
        mem[int'(32'h200 >> 2)] = 32'h80FF0000;
        emit(i_t(12'h203, 5'd0, 3'b000, 5'd2, OPC_LOAD));
        emit(i_t(12'h202, 5'd0, 3'b101, 5'd4, OPC_LOAD));
        emit(i_t(12'h202, 5'd0, 3'b001, 5'd5, OPC_LOAD));
        emit(s_t(12'h300, 5'd2, 5'd0, 3'b010));
        emit(s_t(12'h304, 5'd4, 5'd0, 3'b010));
        emit(s_t(12'h308, 5'd5, 5'd0, 3'b010));
        expect_wr(32'h300, 4'hf, 32'hFFFFFF80);
        expect_wr(32'h304, 4'hf, 32'h000080FF);
        expect_wr(32'h308, 4'hf, 32'hFFFF80FF);
        release_reset();
        finish_prog("load_neg", 6, -1);

        // sub-word stores
        start_reset();
        emit(i_t(12'h0AB, 5'd0, 3'b000, 5'd5, OPC_OPIMM));
        emit(s_t(12'h101, 5'd5, 5'd0, 3'b000));
        emit(s_t(12'h102, 5'd5, 5'd0, 3'b001));
        expect_wr(32'h100, 4'b0010, 32'hABABABAB);
        expect_wr(32'h100, 4'b1100, 32'h00AB00AB);
        release_reset();
        finish_prog("sb_sh", 3, -1);

        // branches and jalr; the store at BASE+12 must be skipped
        start_reset();
        emit(i_t(12'hFFF, 5'd0, 3'b000, 5'd1, OPC_OPIMM));
        emit(i_t(12'h001, 5'd0, 3'b000, 5'd2, OPC_OPIMM));
        emit(b_t(13'd8, 5'd2, 5'd1, 3'b100));
        emit(s_t(12'h3F0, 5'd0, 5'd0, 3'b010));
        emit(b_t(13'd8, 5'd2, 5'd1, 3'b110));
        emit(s_t(12'h3F4, 5'd2, 5'd0, 3'b010));
        emit({20'h00001, 5'd3, OPC_LUI});
        emit(i_t(12'h001, 5'd3, 3'b000, 5'd1, OPC_JALR));
        mem[int'(32'h1000 >> 2)] = s_t(12'h3F8, 5'd1, 5'd0, 3'b010);
        expect_wr(32'h3F4, 4'hf, 32'h00000001);
        expect_wr(32'h3F8, 4'hf, BASE + 32'd32);
        release_reset();
        finish_prog("branch_jalr", 8, -1);

        // fetch stalled five cycles
        start_reset();
        emit(i_t(12'h055, 5'd0, 3'b000, 5'd6, OPC_OPIMM));
        emit(s_t(12'h3FC, 5'd6, 5'd0, 3'b010));
        expect_wr(32'h3FC, 4'hf, 32'h00000055);
        hold = 1'b1;
        release_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_fetch", {35'd0, read_req, addr}, {35'd0, 1'b1, BASE});
        end
        hold = 1'b0;
        finish_prog("stall", 2, -1);

        // misaligned lw: error, no data request, no retire
        start_reset();
        emit(i_t(12'h102, 5'd0, 3'b010, 5'd7, OPC_LOAD));
        release_reset();
        finish_prog("misaligned_lw", 0, 1);
        repeat (3) @(negedge clk);
        check("error_quiet", {66'd0, read_req, write_req}, 68'd0);

        // reset asserted while a store waits for ready
        start_reset();
        emit(i_t(12'h007, 5'd0, 3'b000, 5'd1, OPC_OPIMM));
        emit(s_t(12'h100, 5'd1, 5'd0, 3'b010));
        hold_wr = 1'b1;
        release_reset();
        for (int i = 0; i < 50 && !write_req; i++) @(negedge clk);
        check("store_pending", {67'd0, write_req}, 68'd1);
        #2 reset_n = 1'b0;
        #1 check("reset_drops_wr", {66'd0, write_req, read_req}, 68'd0);
        hold_wr = 1'b0;
        obs_wr_q.delete();
        expect_wr(32'h100, 4'hf, 32'h00000007);
        release_reset();
        @(posedge clk);
        #1 check("refetch", {35'd0, read_req, addr}, {35'd0, 1'b1, BASE});
        finish_prog("reset_mid_store", 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multi-cycle RV32I/RV32E core, successor to the current single-bus CPU. It executes the full base integer ISA: loads and stores of byte, half and word, branches, jal/jalr, and register/immediate ALU ops. It also adds a sticky error indication and a per-instruction retire pulse.
It sits on the same single-port memory bus as today (ready / read_req / write_req / read_data_valid) and reuses the existing alu block.

Parameters:
RESET_PC, 32'h10000000, PC value loaded on reset
NUM_REGS, 32, architectural registers including x0; legal values are 32 (RV32I) or 16 (RV32E)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
ready  in  1  bus accepts the current request at this clock edge
addr  out  32  bus address; always word-aligned (addr[1:0]=0)
write_data  out  32  store data, lane-positioned
byte_enable  out  4  active byte lanes
write_req  out  1  write request
read_req  out  1  read request
read_data  in  32  read return data
read_data_valid  in  1  read_data is valid this cycle
retire  out  1  one-cycle pulse when an instruction commits
error  out  1  sticky; high while in ERROR

Behaviour:
- Reset values: all outputs 0; pc=RESET_PC; all registers 0; state=FETCH_SETUP. Reset asserted mid-transaction drops any request immediately; there is no bus completion obligation.
- Bus handshake:
  - A request (read_req or write_req) plus addr, byte_enable and write_data is held stable until sampled with ready=1. It is deasserted the following cycle.
  - Read data is accepted on the first cycle with read_data_valid=1, which may be the same cycle as ready.
  - Never more than one request outstanding.
- States:
  - FETCH_SETUP: assert read_req, addr=pc, byte_enable=4'hf. Go to FETCH.
  - FETCH: on ready, drop read_req. On read_data_valid, latch instruction and go to DECODE.
  - DECODE: set up ALU operands per opcode.
    - lui/auipc/jal/jalr/op/op-imm/branch go to WRITEBACK.
    - load/store go to MEM_REQ.
    - fence, ecall and ebreak are no-ops that commit.
    - Illegal opcode, illegal funct3, or a register index ≥ NUM_REGS goes to ERROR.
  - MEM_REQ: the ALU result is the effective address ea.
    - Misaligned access goes to ERROR: lh/lhu/sh with ea[0]=1; lw/sw with ea[1:0]≠0.
    - Otherwise: addr={ea[31:2],2'b00}.
    - Stores: byte_enable = 4'b0001<<ea[1:0] (sb) or 4'b0011<<ea[1:0] (sh) or 4'hf (sw). write_data = rs2 replicated to every lane. Assert write_req.
    - Loads: byte_enable=4'hf, assert read_req.
    - Go to MEM_WAIT.
  - MEM_WAIT:
    - Store: complete on ready.
    - Load: complete on read_data_valid. Shift by ea[1:0]*8, then sign-extend (lb/lh) or zero-extend (lbu/lhu).
    - Go to WRITEBACK.
  - WRITEBACK:
    - Write rd; writes to x0 are discarded.
    - Compute pc_next:
      - jal: pc+J-immediate.
      - jalr: (rs1+I-immediate) & ~1.
      - Taken branch: pc+B-immediate.
      - Otherwise: pc+4.
    - Branch conditions: beq/bne via rs1==rs2; blt/bge signed; bltu/bgeu unsigned. A dedicated comparator is used, not the ALU.
    - jal/jalr write pc+4 to rd.
    - If pc_next[1:0]≠0: go to ERROR with no register write and no retire.
    - Otherwise: pulse retire, update pc, issue the fetch request directly (as in FETCH_SETUP), and go to FETCH.
  - ERROR: terminal until reset; error=1, no bus activity.
- Arithmetic: all 32-bit, wrap-around. Shift amount is rs2[4:0] (op) or instr[24:20] (op-imm). srai/sra are selected by instr[30].
- Latency at zero wait states:
  - ALU/branch/jump: 4 cycles fetch-to-retire.
  - Load/store: 6 cycles.
- A read_data_valid arriving with no read outstanding is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - alu_op_t (existing).
  - Opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM.
  - The state enum cpu_state_t.
- Instantiate the existing alu sub-module.
- Natural new sub-module: cpu_load_align, a combinational lane-extract and sign/zero-extend unit with inputs read_data, ea[1:0] and funct3.

Test Plan:
- addi x1,x0,-5; sw x1,0x100(x0) -> write_req with addr=0x100, byte_enable=4'hf, write_data=32'hFFFFFFFB; retire pulses twice.
- Memory word 0x11223344 at 0x200; lb x2,0x203(x0); lbu x3,0x203(x0); lh x4,0x202(x0) -> x2=0x00000011, x3=0x00000011, x4=0x00001122. Repeat with word 0x80FF0000: lb x2,0x203 -> 0xFFFFFF80; lhu x4,0x202 -> 0x000080FF.
- sb x5,0x101(x0) with x5=0xAB -> byte_enable=4'b0010, write_data=32'hABABABAB.
- x1=-1, x2=1: blt x1,x2,+8 is taken (pc+8); bltu x1,x2,+8 is not taken (pc+4). jalr x1,x3,1 with x3=0x1000 -> pc=0x1000, x1=old pc+4.
- ready held low 5 cycles during fetch -> read_req and addr stay stable; instruction executes correctly after ready.
- lw from 0x102 -> error=1, no bus request issued, no retire. Separately, reset_n pulsed low mid-store -> write_req=0 immediately; fetch restarts at RESET_PC.
